// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one multiplier bit per cycle.
// Optional two's-complement mode (tc port) is enabled by defining MULT_SIGNED_EN.
module seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic               tc,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p,
  output logic [1:0]         state_dbg
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = PW + 1;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state_q;
  logic [AW-1:0]  mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]  cnt_q;
  logic [AW-1:0]  acc_q;
  logic [AW-1:0]  acc_d;
  logic [AW-1:0]  addend;
  logic [AW-1:0]  mcand_ext;
  logic [PW-1:0]  p_q;
  logic           busy_q;
  logic           done_q;
  logic           last_bit;
`ifdef MULT_SIGNED_EN
  logic           tc_q;
`endif

  // Handshake: start is taken on any rising edge where busy=0 (IDLE or DONE);
  // done pulses for exactly one cycle, and p is valid from that cycle until the next completion.

`ifdef MULT_SIGNED_EN
  assign mcand_ext = {{(AW-WIDTH){tc & a[WIDTH-1]}}, a};
`else
  assign mcand_ext = AW'(a);
`endif

  always_comb begin
    addend   = mplier_q[0] ? (mcand_q << cnt_q) : '0;
    last_bit = (cnt_q == CW'(WIDTH - 1));
`ifdef MULT_SIGNED_EN
    // The multiplier MSB carries negative weight in two's complement.
    acc_d = (tc_q && last_bit) ? (acc_q - addend) : (acc_q + addend);
`else
    acc_d = acc_q + addend;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULT_SIGNED_EN
      tc_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= mcand_ext;
            mplier_q <= b;
            cnt_q    <= '0;
            acc_q    <= '0;
`ifdef MULT_SIGNED_EN
            tc_q     <= tc;
`endif
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (last_bit) begin
            p_q     <= acc_d[PW-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign p         = p_q;
  assign state_dbg = state_q;

endmodule
